// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (LSU/DMA) data-memory arbiter with registered responses.
//            Define DMEM_ARB_RR_EN for burst-limited round robin, else fixed m0 priority.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_t;

  localparam int                c_bcnt_w = $clog2(MAX_BURST + 1);
  localparam logic [c_bcnt_w-1:0] c_max  = c_bcnt_w'(MAX_BURST);
  localparam logic [c_bcnt_w-1:0] c_one  = c_bcnt_w'(1);
  localparam logic [ADDR_W:0]   c_depth  = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              r_state, w_state_nxt;
  logic [c_bcnt_w-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic                w_pick_m0, w_gnt0, w_gnt1, w_any;
  logic                w_ok0, w_ok1, w_sel_ok, w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata, w_resp_data;
  logic                r_rvalid0, r_rvalid1, r_err0, r_err1;
  logic [DATA_W-1:0]   r_rdata0, r_rdata1;

  assign w_ok0 = ({1'b0, m0_addr} < c_depth);
  assign w_ok1 = ({1'b0, m1_addr} < c_depth);

  always_comb begin
    w_pick_m0 = 1'b1;
`ifdef DMEM_ARB_RR_EN
    // Owner keeps the bus until its burst saturates, then yields on a tie.
    case (r_state)
      OWN_M0:  w_pick_m0 = (r_bcnt < c_max);
      OWN_M1:  w_pick_m0 = (r_bcnt >= c_max);
      default: w_pick_m0 = 1'b1;
    endcase
`endif
    w_gnt0 = reset & m0_req & (w_pick_m0 | ~m1_req);
    w_gnt1 = reset & m1_req & ~w_gnt0;
    w_any  = w_gnt0 | w_gnt1;
  end

  always_comb begin
    w_bcnt_inc  = (r_bcnt >= c_max) ? c_max : r_bcnt + c_one;
    w_state_nxt = IDLE;
    w_bcnt_nxt  = '0;
    if (w_gnt0) begin
      w_state_nxt = OWN_M0;
      w_bcnt_nxt  = (r_state == OWN_M0) ? w_bcnt_inc : c_one;
    end else if (w_gnt1) begin
      w_state_nxt = OWN_M1;
      w_bcnt_nxt  = (r_state == OWN_M1) ? w_bcnt_inc : c_one;
    end
  end

  always_comb begin
    w_sel_we    = w_gnt0 ? m0_we    : m1_we;
    w_sel_ok    = w_gnt0 ? w_ok0    : w_ok1;
    w_sel_addr  = w_gnt0 ? m0_addr  : m1_addr;
    w_sel_wdata = w_gnt0 ? m0_wdata : m1_wdata;
    mem_addr    = w_any ? w_sel_addr  : '0;
    mem_wdata   = w_any ? w_sel_wdata : '0;
    // Out-of-range accesses are granted but never reach the memory.
    mem_wr_en   = w_any & w_sel_ok & w_sel_we;
    mem_rd_en   = w_any & w_sel_ok & ~w_sel_we;
    w_resp_data = (w_sel_ok & ~w_sel_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bcnt    <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
      if (w_gnt0) begin
        r_rdata0 <= w_resp_data;
        r_err0   <= ~w_ok0;
      end
      if (w_gnt1) begin
        r_rdata1 <= w_resp_data;
        r_err1   <= ~w_ok1;
      end
    end
  end

  // Responses are masked while reset is low so a pending pulse never escapes.
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0 & reset;
  assign m1_rvalid = r_rvalid1 & reset;
  assign m0_err    = r_err0 & reset;
  assign m1_err    = r_err1 & reset;
  assign m0_rdata  = reset ? r_rdata0 : '0;
  assign m1_rdata  = reset ? r_rdata1 : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed scoreboard bench for dmem_arbiter with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic [32:0] e0, e1;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(negedge clk) if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response monitor: each rvalid pulse consumes the oldest expected entry.
  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) check("m0_rvalid_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("m0_rdata", m0_rdata, e0[31:0]);
        check("m0_err", m0_err, e0[32]);
      end
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) check("m1_rvalid_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("m1_rdata", m1_rdata, e1[31:0]);
        check("m1_err", m1_err, e1[32]);
      end
    end
  end

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic step(input logic eg0, input logic eg1);
    @(negedge clk);
    check("m0_gnt", m0_gnt, eg0);
    check("m1_gnt", m1_gnt, eg1);
  endtask

  task automatic next_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    reset = 1'b0;
    set_m0(0, 0, 0, 0);
    set_m1(1, 1, 32'd3, 32'h1);

    // Write attempted during reset must be blocked.
    for (int i = 0; i < 2; i++) begin
      step(0, 0);
      check("rst_mem_wr_en", mem_wr_en, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_m1_rdata", m1_rdata, 0);
      check("rst_m1_err", m1_err, 0);
      next_edge();
    end

    // First cycle out of reset: m0 write then read of addr 5.
    reset = 1'b1;
    set_m1(0, 0, 0, 0);
    set_m0(1, 1, 32'd5, 32'hDEADBEEF);
    step(1, 0);
    check("wr_mem_wr_en", mem_wr_en, 1);
    check("wr_mem_addr", mem_addr, 5);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    q0.push_back({1'b0, 32'h0});
    next_edge();
    set_m0(1, 0, 32'd5, 32'h0);
    step(1, 0);
    check("rd_mem_rd_en", mem_rd_en, 1);
    check("rd_mem_wr_en", mem_wr_en, 0);
    q0.push_back({1'b0, 32'hDEADBEEF});
    next_edge();

    // Addr 3 keeps its pre-reset content.
    set_m0(0, 0, 0, 0);
    set_m1(1, 0, 32'd3, 32'h0);
    step(0, 1);
    q1.push_back({1'b0, 32'hA000_0003});
    next_edge();
    set_m1(1, 0, 32'd1024, 32'h0);
    step(0, 1);
    check("oor_rd_mem_rd_en", mem_rd_en, 0);
    q1.push_back({1'b1, 32'h0});
    next_edge();
    set_m1(1, 1, 32'd2000, 32'h55);
    step(0, 1);
    check("oor_wr_mem_wr_en", mem_wr_en, 0);
    q1.push_back({1'b1, 32'h0});
    next_edge();
    set_m1(1, 0, 32'd1023, 32'h0);
    step(0, 1);
    check("edge_mem_rd_en", mem_rd_en, 1);
    q1.push_back({1'b0, 32'hA000_03FF});
    next_edge();
    set_m1(0, 0, 0, 0);
    step(0, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_mem_rd_en", mem_rd_en, 0);
    next_edge();
    step(0, 0);
    check("hold_m1_rdata", m1_rdata, 32'hA000_03FF);
    check("hold_m1_err", m1_err, 0);
    check("hold_m1_rvalid", m1_rvalid, 0);
    next_edge();

`ifdef DMEM_ARB_RR_EN
    // Tie from IDLE goes to m0; m1 then bursts 4 beats before m0 gets back in.
    set_m0(1, 0, 32'd7, 0);
    set_m1(1, 0, 32'd30, 0);
    step(1, 0); q0.push_back({1'b0, 32'hA000_0007}); next_edge();
    set_m0(0, 0, 0, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_001E}); next_edge();
    set_m0(1, 0, 32'd8, 0);
    set_m1(1, 0, 32'd31, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_001F}); next_edge();
    set_m1(1, 0, 32'd32, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_0020}); next_edge();
    set_m1(1, 0, 32'd33, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_0021}); next_edge();
    set_m1(1, 0, 32'd34, 0);
    step(1, 0); q0.push_back({1'b0, 32'hA000_0008}); next_edge();
    set_m0(0, 0, 0, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_0022}); next_edge();
    set_m1(1, 0, 32'd35, 0);
    step(0, 1); q1.push_back({1'b0, 32'hA000_0023}); next_edge();
    set_m1(0, 0, 0, 0);
`else
    // Fixed priority: m0 wins every tie; m1 waits until m0 drops.
    set_m1(1, 0, 32'd20, 0);
    for (int i = 0; i < 3; i++) begin
      set_m0(1, 0, 32'd10 + i, 0);
      step(1, 0);
      q0.push_back({1'b0, 32'hA000_000A + i});
      next_edge();
    end
    set_m0(0, 0, 0, 0);
    step(0, 1);
    q1.push_back({1'b0, 32'hA000_0014});
    next_edge();
    set_m1(0, 0, 0, 0);
`endif
    step(0, 0);
    next_edge();

    // Reset in the cycle after a grant kills the pending response.
    set_m0(1, 0, 32'd9, 0);
    step(1, 0);
    next_edge();
    reset = 1'b0;
    step(0, 0);
    check("midrst_m0_rvalid", m0_rvalid, 0);
    check("midrst_mem_rd_en", mem_rd_en, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_m0_rdata", m0_rdata, 0);
    check("midrst_m1_rdata", m1_rdata, 0);
    check("midrst_m1_err", m1_err, 0);
    next_edge();
    reset = 1'b1;
    set_m0(0, 0, 0, 0);
    step(0, 0);
    check("postrst_m1_rdata", m1_rdata, 0);
    check("postrst_m0_rvalid", m0_rvalid, 0);
    next_edge();
    step(0, 0);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
